// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational instruction
// memory, and buffers fetched words in a small FIFO presented to decode over
// valid/ready. Handles redirect with flush, external halt and halt-on-HALT_WORD.
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [1:0]  state_o,
   output logic [31:0] fetch_cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHalt = 2'b10
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     fetch_cnt_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [31:0]     q_instr [DEPTH];
   logic [31:0]     q_pc    [DEPTH];
   logic [31:0]     last_instr_q, last_pc_q;

   logic            pop, fetch, push, is_halt_word;

   // Handshake and fetch qualification
   always_comb begin
      dec_valid    = (count_q != '0);
      pop          = dec_valid && dec_ready;
      is_halt_word = (imem_instr == HALT_WORD);
      fetch        = (state_q == StRun) && !halt_req && !redirect_valid &&
                     ((count_q < DepthC) || pop);
      push         = fetch && !is_halt_word;
   end

   // Next-state and next-pc logic; redirect freezes the state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (halt_req || (fetch && is_halt_word)) state_d = StHalt;
         StHalt:  if (start) state_d = StRun;
         default: state_d = StIdle;
      endcase
      if (redirect_valid) begin
         state_d = state_q;
         pc_d    = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // Control state, pointers and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         fetch_cnt_q  <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         last_instr_q <= '0;
         last_pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         // Remember the head so dec_* hold their value once the queue drains
         if (dec_valid) begin
            last_instr_q <= q_instr[rd_ptr_q];
            last_pc_q    <= q_pc[rd_ptr_q];
         end
         if (redirect_valid) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage; contents are only observed through count_q so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr_q] <= imem_instr;
         q_pc[wr_ptr_q]    <= pc_q;
      end
   end

   // Output drive
   always_comb begin
      imem_addr = pc_q;
      state_o   = state_q;
      fetch_cnt = fetch_cnt_q;
      dec_instr = dec_valid ? q_instr[rd_ptr_q] : last_instr_q;
      dec_pc    = dec_valid ? q_pc[rd_ptr_q]    : last_pc_q;
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed stimulus, scoreboard of expected {pc, instr}
// pairs consumed by an independent monitor on each decode handshake.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, halt_req, redirect_valid, dec_ready;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_instr, dec_instr, dec_pc, fetch_cnt;
   logic        dec_valid;
   logic [1:0]  state_o;

   logic [31:0] mem [0:1023];
   logic [63:0] sb [$];
   int          vectors = 0;
   int          errors  = 0;
   int          n_deliv = 0;
   int          d0;

   assign imem_instr = mem[imem_addr[11:2]];

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .state_o        (state_o),
      .fetch_cnt      (fetch_cnt)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] pc);
      sb.push_back({pc, mem[pc[11:2]]});
   endtask

   // Reset, then one start pulse: leaves the DUT in RUN at RESET_PC
   task automatic reset_and_start();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Monitor: every accepted head must match the oldest expected entry
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (!reset && dec_valid && dec_ready) begin
            n_deliv++;
            vectors++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL deliver: got pc=%h instr=%h expected nothing", dec_pc, dec_instr);
            end else begin
               exp = sb.pop_front();
               if ({dec_pc, dec_instr} !== exp) begin
                  errors++;
                  $display("FAIL deliver: got pc=%h instr=%h expected pc=%h instr=%h",
                           dec_pc, dec_instr, exp[63:32], exp[31:0]);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | i;
      mem[0] = 32'h8C01_0000;
      mem[1] = 32'h8C02_0004;
      mem[2] = 32'h8C03_0008;
      mem[3] = 32'h2004_0064;
      reset = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; dec_ready = 1'b0;
      tick(2);

      // Reset values
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_instr", dec_instr, 32'd0);
      chk("rst_pc", dec_pc, 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_cnt", fetch_cnt, 32'd0);

      // 1: streaming fetch, four words back to back
      sb.push_back({32'h0, 32'h8C01_0000});
      sb.push_back({32'h4, 32'h8C02_0004});
      sb.push_back({32'h8, 32'h8C03_0008});
      sb.push_back({32'hC, 32'h2004_0064});
      reset_and_start();
      chk("t1_state_run", 32'(state_o), 32'd1);
      dec_ready = 1'b1;
      d0 = n_deliv;
      tick(4);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      chk("t1_deliv", 32'(n_deliv - d0), 32'd4);
      chk("t1_cnt", fetch_cnt, 32'd4);
      chk("t1_state_halt", 32'(state_o), 32'd2);

      // 2: backpressure fills exactly DEPTH entries, then drains in order
      dec_ready = 1'b0;
      reset_and_start();
      tick(3);
      chk("t2_addr_a", imem_addr, 32'h8);
      chk("t2_cnt_a", fetch_cnt, 32'd2);
      tick(2);
      chk("t2_addr_b", imem_addr, 32'h8);
      chk("t2_cnt_b", fetch_cnt, 32'd2);
      chk("t2_head", dec_pc, 32'h0);
      expect_word(32'h0);
      expect_word(32'h4);
      expect_word(32'h8);
      d0 = n_deliv;
      dec_ready = 1'b1;
      tick(1);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      tick(1);
      chk("t2_deliv", 32'(n_deliv - d0), 32'd3);
      chk("t2_cnt_c", fetch_cnt, 32'd3);
      chk("t2_valid", 32'(dec_valid), 32'd0);
      chk("t2_hold_pc", dec_pc, 32'h8);

      // 3: redirect while full flushes and realigns the pc
      dec_ready = 1'b0;
      reset_and_start();
      tick(2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0023;
      tick(1);
      redirect_valid = 1'b0;
      chk("t3_valid", 32'(dec_valid), 32'd0);
      chk("t3_addr", imem_addr, 32'h20);
      chk("t3_state", 32'(state_o), 32'd1);
      expect_word(32'h20);
      expect_word(32'h24);
      d0 = n_deliv;
      dec_ready = 1'b1;
      tick(2);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      chk("t3_deliv", 32'(n_deliv - d0), 32'd2);

      // 4: HALT_WORD stops fetch without being delivered; restart re-halts
      mem[4] = 32'hFC00_0000;
      reset_and_start();
      sb.push_back({32'h0, 32'h8C01_0000});
      sb.push_back({32'h4, 32'h8C02_0004});
      sb.push_back({32'h8, 32'h8C03_0008});
      sb.push_back({32'hC, 32'h2004_0064});
      d0 = n_deliv;
      tick(5);
      chk("t4_deliv", 32'(n_deliv - d0), 32'd4);
      chk("t4_state", 32'(state_o), 32'd2);
      chk("t4_addr", imem_addr, 32'h10);
      chk("t4_cnt", fetch_cnt, 32'd4);
      chk("t4_valid", 32'(dec_valid), 32'd0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t4_rerun", 32'(state_o), 32'd1);
      tick(1);
      chk("t4_rehalt", 32'(state_o), 32'd2);
      chk("t4_readdr", imem_addr, 32'h10);
      chk("t4_recnt", fetch_cnt, 32'd4);
      mem[4] = 32'h2000_0004;

      // 5: halt_req beats start; then reset mid-RUN with a full queue
      dec_ready = 1'b0;
      reset_and_start();
      tick(1);
      halt_req = 1'b1;
      start = 1'b1;
      tick(1);
      halt_req = 1'b0;
      start = 1'b0;
      chk("t5_state", 32'(state_o), 32'd2);
      chk("t5_cnt", fetch_cnt, 32'd1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      chk("t5_full_cnt", fetch_cnt, 32'd2);
      chk("t5_full_valid", 32'(dec_valid), 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t5_rst_valid", 32'(dec_valid), 32'd0);
      chk("t5_rst_state", 32'(state_o), 32'd0);
      chk("t5_rst_addr", imem_addr, 32'h0);
      chk("t5_rst_cnt", fetch_cnt, 32'd0);

      // 6: pc wraps from FFFFFFFC to 0
      reset_and_start();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick(1);
      redirect_valid = 1'b0;
      chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
      expect_word(32'hFFFF_FFFC);
      expect_word(32'h0);
      d0 = n_deliv;
      dec_ready = 1'b1;
      tick(2);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      chk("t6_deliv", 32'(n_deliv - d0), 32'd2);
      chk("t6_addr_end", imem_addr, 32'h4);

      tick(2);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
